// File: rtl/sram_axi_pkg.sv
// Shared types and AXI tie-off constants for the SRAM-like to AXI3 bridge.
package sram_axi_pkg;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_AR   = 2'd1,
        R_R    = 2'd2
    } r_state_e;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_REQ  = 2'd1,
        W_B    = 2'd2
    } w_state_e;

    localparam int          ID_INST    = 0;
    localparam int          ID_DATA    = 1;
    localparam logic [1:0]  BURST_INCR = 2'b01;

    localparam logic [3:0]  AXI_LEN    = 4'd0;
    localparam logic [1:0]  AXI_LOCK   = 2'd0;
    localparam logic [3:0]  AXI_CACHE  = 4'd0;
    localparam logic [2:0]  AXI_PROT   = 3'd0;

endpackage

// File: rtl/sram_axi_bridge.sv
// Converts inst/data SRAM-like requests into single-beat AXI3 transactions,
// with at most one read and one write outstanding.
module sram_axi_bridge
    import sram_axi_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ID_W   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              inst_sram_req,
    input  logic              inst_sram_wr,
    input  logic [1:0]        inst_sram_size,
    input  logic [3:0]        inst_sram_wstrb,
    input  logic [ADDR_W-1:0] inst_sram_addr,
    input  logic [DATA_W-1:0] inst_sram_wdata,
    output logic              inst_sram_addr_ok,
    output logic              inst_sram_data_ok,
    output logic [DATA_W-1:0] inst_sram_rdata,
    input  logic              data_sram_req,
    input  logic              data_sram_wr,
    input  logic [1:0]        data_sram_size,
    input  logic [3:0]        data_sram_wstrb,
    input  logic [ADDR_W-1:0] data_sram_addr,
    input  logic [DATA_W-1:0] data_sram_wdata,
    output logic              data_sram_addr_ok,
    output logic              data_sram_data_ok,
    output logic [DATA_W-1:0] data_sram_rdata,
    output logic [ID_W-1:0]   arid,
    output logic [ADDR_W-1:0] araddr,
    output logic [3:0]        arlen,
    output logic [2:0]        arsize,
    output logic [1:0]        arburst,
    output logic [1:0]        arlock,
    output logic [3:0]        arcache,
    output logic [2:0]        arprot,
    output logic              arvalid,
    input  logic              arready,
    input  logic [ID_W-1:0]   rid,
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        rresp,
    input  logic              rlast,
    input  logic              rvalid,
    output logic              rready,
    output logic [ID_W-1:0]   awid,
    output logic [ADDR_W-1:0] awaddr,
    output logic [3:0]        awlen,
    output logic [2:0]        awsize,
    output logic [1:0]        awburst,
    output logic [1:0]        awlock,
    output logic [3:0]        awcache,
    output logic [2:0]        awprot,
    output logic              awvalid,
    input  logic              awready,
    output logic [ID_W-1:0]   wid,
    output logic [DATA_W-1:0] wdata,
    output logic [3:0]        wstrb,
    output logic              wlast,
    output logic              wvalid,
    input  logic              wready,
    input  logic [ID_W-1:0]   bid,
    input  logic [1:0]        bresp,
    input  logic              bvalid,
    output logic              bready
);

    r_state_e          r_state_q, r_state_d;
    w_state_e          w_state_q, w_state_d;
    logic              r_is_data_q, r_is_data_d;
    logic [ADDR_W-1:0] araddr_q, araddr_d;
    logic [1:0]        arsize_q, arsize_d;
    logic [ADDR_W-1:0] awaddr_q, awaddr_d;
    logic [1:0]        awsize_q, awsize_d;
    logic [3:0]        wstrb_q, wstrb_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              awvalid_q, awvalid_d;
    logic              wvalid_q, wvalid_d;

    logic data_busy, data_wr_acc, data_rd_acc, inst_rd_acc;
    logic aw_done, w_done;

    // A write is always a data-side transaction, so any active write counts.
    assign data_busy   = (r_state_q != R_IDLE && r_is_data_q) || (w_state_q != W_IDLE);
    assign data_wr_acc = data_sram_req && data_sram_wr && (w_state_q == W_IDLE) && !data_busy;
    assign data_rd_acc = data_sram_req && !data_sram_wr && (r_state_q == R_IDLE)
                         && (w_state_q == W_IDLE) && !data_busy;
    assign inst_rd_acc = inst_sram_req && (r_state_q == R_IDLE) && !data_rd_acc;

    assign inst_sram_addr_ok = inst_rd_acc;
    assign data_sram_addr_ok = data_rd_acc || data_wr_acc;

    always_comb begin
        r_state_d   = r_state_q;
        r_is_data_d = r_is_data_q;
        araddr_d    = araddr_q;
        arsize_d    = arsize_q;
        case (r_state_q)
            R_IDLE: if (data_rd_acc || inst_rd_acc) begin
                r_state_d   = R_AR;
                r_is_data_d = data_rd_acc;
                araddr_d    = data_rd_acc ? data_sram_addr : inst_sram_addr;
                arsize_d    = data_rd_acc ? data_sram_size : inst_sram_size;
            end
            R_AR:    if (arready) r_state_d = R_R;
            R_R:     if (rvalid)  r_state_d = R_IDLE;
            default: r_state_d = R_IDLE;
        endcase
    end

    // AW and W handshake independently; leave W_REQ once neither is pending.
    assign aw_done = !awvalid_q || awready;
    assign w_done  = !wvalid_q  || wready;

    always_comb begin
        w_state_d = w_state_q;
        awaddr_d  = awaddr_q;
        awsize_d  = awsize_q;
        wstrb_d   = wstrb_q;
        wdata_d   = wdata_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        case (w_state_q)
            W_IDLE: if (data_wr_acc) begin
                w_state_d = W_REQ;
                awaddr_d  = data_sram_addr;
                awsize_d  = data_sram_size;
                wstrb_d   = data_sram_wstrb;
                wdata_d   = data_sram_wdata;
                awvalid_d = 1'b1;
                wvalid_d  = 1'b1;
            end
            W_REQ: begin
                if (awready) awvalid_d = 1'b0;
                if (wready)  wvalid_d  = 1'b0;
                if (aw_done && w_done) w_state_d = W_B;
            end
            W_B:     if (bvalid) w_state_d = W_IDLE;
            default: w_state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state_q   <= R_IDLE;
            w_state_q   <= W_IDLE;
            r_is_data_q <= 1'b0;
            araddr_q    <= '0;
            arsize_q    <= '0;
            awaddr_q    <= '0;
            awsize_q    <= '0;
            wstrb_q     <= '0;
            wdata_q     <= '0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
        end else begin
            r_state_q   <= r_state_d;
            w_state_q   <= w_state_d;
            r_is_data_q <= r_is_data_d;
            araddr_q    <= araddr_d;
            arsize_q    <= arsize_d;
            awaddr_q    <= awaddr_d;
            awsize_q    <= awsize_d;
            wstrb_q     <= wstrb_d;
            wdata_q     <= wdata_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
        end
    end

    assign arid    = r_is_data_q ? ID_W'(ID_DATA) : ID_W'(ID_INST);
    assign araddr  = araddr_q;
    assign arsize  = {1'b0, arsize_q};
    assign arvalid = (r_state_q == R_AR);
    assign rready  = (r_state_q == R_R);

    assign awid    = ID_W'(ID_DATA);
    assign awaddr  = awaddr_q;
    assign awsize  = {1'b0, awsize_q};
    assign awvalid = awvalid_q;
    assign wid     = ID_W'(ID_DATA);
    assign wdata   = wdata_q;
    assign wstrb   = wstrb_q;
    assign wvalid  = wvalid_q;
    assign wlast   = wvalid_q;
    assign bready  = (w_state_q == W_B);

    // The R beat is steered by the latched source, never by rid.
    assign inst_sram_data_ok = rready && !r_is_data_q && rvalid;
    assign data_sram_data_ok = (rready && r_is_data_q && rvalid) || (bready && bvalid);
    assign inst_sram_rdata   = rdata;
    assign data_sram_rdata   = rdata;

    assign arlen   = AXI_LEN;
    assign arburst = BURST_INCR;
    assign arlock  = AXI_LOCK;
    assign arcache = AXI_CACHE;
    assign arprot  = AXI_PROT;
    assign awlen   = AXI_LEN;
    assign awburst = BURST_INCR;
    assign awlock  = AXI_LOCK;
    assign awcache = AXI_CACHE;
    assign awprot  = AXI_PROT;

    logic unused_inputs;
    assign unused_inputs = ^{inst_sram_wr, inst_sram_wstrb, inst_sram_wdata,
                             rid, rresp, rlast, bid, bresp};

endmodule

// File: tb/tb_sram_axi_bridge.sv
// Directed bench for sram_axi_bridge: the AXI slave side is driven by hand.
module tb_sram_axi_bridge;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_sram_req, inst_sram_wr;
    logic [1:0]  inst_sram_size;
    logic [3:0]  inst_sram_wstrb;
    logic [31:0] inst_sram_addr, inst_sram_wdata;
    logic        inst_sram_addr_ok, inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;
    logic        data_sram_req, data_sram_wr;
    logic [1:0]  data_sram_size;
    logic [3:0]  data_sram_wstrb;
    logic [31:0] data_sram_addr, data_sram_wdata;
    logic        data_sram_addr_ok, data_sram_data_ok;
    logic [31:0] data_sram_rdata;
    logic [3:0]  arid, awid, wid, rid, bid;
    logic [31:0] araddr, awaddr, rdata, wdata;
    logic [3:0]  arlen, arcache, awlen, awcache, wstrb;
    logic [2:0]  arsize, arprot, awsize, awprot;
    logic [1:0]  arburst, arlock, awburst, awlock, rresp, bresp;
    logic        arvalid, arready, rlast, rvalid, rready;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    sram_axi_bridge #(.ADDR_W(32), .DATA_W(32), .ID_W(4)) dut (
        .clk(clk), .reset(reset),
        .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr),
        .inst_sram_size(inst_sram_size), .inst_sram_wstrb(inst_sram_wstrb),
        .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
        .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok),
        .inst_sram_rdata(inst_sram_rdata),
        .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
        .data_sram_size(data_sram_size), .data_sram_wstrb(data_sram_wstrb),
        .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
        .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok),
        .data_sram_rdata(data_sram_rdata),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid),
        .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
        .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid),
        .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid),
        .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge; combinational checks follow a further #1.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        inst_sram_req = 0; inst_sram_wr = 0; inst_sram_size = 2'd2; inst_sram_wstrb = 4'hF;
        inst_sram_addr = 0; inst_sram_wdata = 0;
        data_sram_req = 0; data_sram_wr = 0; data_sram_size = 2'd2; data_sram_wstrb = 4'hF;
        data_sram_addr = 0; data_sram_wdata = 0;
        arready = 0; rid = 0; rdata = 0; rresp = 0; rlast = 1; rvalid = 0;
        awready = 0; wready = 0; bid = 0; bresp = 0; bvalid = 0;
        #12;
        chk("rst_arvalid", arvalid, 0);
        chk("rst_awvalid", awvalid, 0);
        chk("rst_wvalid", wvalid, 0);
        chk("rst_rready", rready, 0);
        chk("rst_bready", bready, 0);
        chk("rst_araddr", araddr, 0);
        chk("rst_awaddr", awaddr, 0);
        chk("rst_wdata", wdata, 0);
        chk("const_arburst", arburst, 2'b01);
        chk("const_awburst", awburst, 2'b01);
        chk("const_arlen", arlen, 0);
        chk("const_awprot", awprot, 0);
        step(); reset = 1'b0;
        step();

        // 1: single inst read, minimum latency
        inst_sram_req = 1; inst_sram_addr = 32'h1C00_0000; inst_sram_size = 2'd2; #1;
        chk("t1_inst_addr_ok", inst_sram_addr_ok, 1);
        chk("t1_data_addr_ok", data_sram_addr_ok, 0);
        chk("t1_arvalid_c0", arvalid, 0);
        step(); inst_sram_req = 0; arready = 1; #1;
        chk("t1_arvalid", arvalid, 1);
        chk("t1_arid", arid, 0);
        chk("t1_arsize", arsize, 3'd2);
        chk("t1_araddr", araddr, 32'h1C00_0000);
        step(); rvalid = 1; rdata = 32'hDEAD_BEEF; #1;
        chk("t1_rready", rready, 1);
        chk("t1_inst_data_ok", inst_sram_data_ok, 1);
        chk("t1_inst_rdata", inst_sram_rdata, 32'hDEAD_BEEF);
        chk("t1_data_data_ok", data_sram_data_ok, 0);
        step(); rvalid = 0; #1;
        chk("t1_rready_idle", rready, 0);
        chk("t1_arvalid_idle", arvalid, 0);

        // 2: inst/data read collision, data wins
        inst_sram_req = 1; inst_sram_addr = 32'h300;
        data_sram_req = 1; data_sram_wr = 0; data_sram_addr = 32'h200; #1;
        chk("t2_data_addr_ok", data_sram_addr_ok, 1);
        chk("t2_inst_addr_ok", inst_sram_addr_ok, 0);
        step(); data_sram_req = 0; #1;
        chk("t2_arid_data", arid, 1);
        chk("t2_araddr_data", araddr, 32'h200);
        chk("t2_inst_blocked_ar", inst_sram_addr_ok, 0);
        step(); rvalid = 1; rdata = 32'h1111_2222; #1;
        chk("t2_data_data_ok", data_sram_data_ok, 1);
        chk("t2_data_rdata", data_sram_rdata, 32'h1111_2222);
        chk("t2_inst_data_ok_0", inst_sram_data_ok, 0);
        chk("t2_inst_blocked_r", inst_sram_addr_ok, 0);
        step(); rvalid = 0; #1;
        chk("t2_inst_addr_ok", inst_sram_addr_ok, 1);
        step(); inst_sram_req = 0; #1;
        chk("t2_arid_inst", arid, 0);
        chk("t2_araddr_inst", araddr, 32'h300);
        step(); rvalid = 1; rdata = 32'h3333_4444; #1;
        chk("t2_inst_data_ok", inst_sram_data_ok, 1);
        step(); rvalid = 0;

        // 3: data write, W handshake 3 cycles after AW; a data read waits behind it
        awready = 1; wready = 0;
        data_sram_req = 1; data_sram_wr = 1; data_sram_addr = 32'h100; data_sram_size = 2'd1;
        data_sram_wstrb = 4'b0011; data_sram_wdata = 32'hAAAA_5555; #1;
        chk("t3_wr_addr_ok", data_sram_addr_ok, 1);
        step(); data_sram_wr = 0; data_sram_size = 2'd2; #1;
        chk("t3_awvalid", awvalid, 1);
        chk("t3_wvalid", wvalid, 1);
        chk("t3_wlast", wlast, 1);
        chk("t3_awsize", awsize, 3'd1);
        chk("t3_wstrb", wstrb, 4'b0011);
        chk("t3_awaddr", awaddr, 32'h100);
        chk("t3_wdata", wdata, 32'hAAAA_5555);
        chk("t3_awid", awid, 1);
        chk("t3_rd_blocked0", data_sram_addr_ok, 0);
        step(); awready = 0; #1;
        chk("t3_awvalid_drop", awvalid, 0);
        chk("t3_wvalid_hold", wvalid, 1);
        chk("t3_rd_blocked1", data_sram_addr_ok, 0);
        step(); #1;
        chk("t3_wvalid_hold2", wvalid, 1);
        step(); wready = 1; #1;
        chk("t3_rd_blocked2", data_sram_addr_ok, 0);
        step(); wready = 0; #1;
        chk("t3_wvalid_drop", wvalid, 0);
        chk("t3_bready", bready, 1);
        chk("t3_no_ok_wo_b", data_sram_data_ok, 0);
        chk("t3_rd_blocked3", data_sram_addr_ok, 0);
        step(); bvalid = 1; #1;
        chk("t3_data_ok_b", data_sram_data_ok, 1);
        chk("t3_rd_blocked4", data_sram_addr_ok, 0);
        step(); bvalid = 0; #1;
        chk("t3_bready_idle", bready, 0);
        chk("t3_rd_accept", data_sram_addr_ok, 1);
        step(); data_sram_req = 0; #1;
        chk("t3_rd_araddr", araddr, 32'h100);
        chk("t3_rd_arid", arid, 1);
        step(); rvalid = 1; rdata = 32'h0000_5555; #1;
        chk("t3_rd_data_ok", data_sram_data_ok, 1);
        step(); rvalid = 0;

        // 4: inst read completes while a data write waits for B
        awready = 1; wready = 1;
        data_sram_req = 1; data_sram_wr = 1; data_sram_addr = 32'h40;
        data_sram_wstrb = 4'hF; data_sram_wdata = 32'h1234_5678; #1;
        chk("t4_wr_addr_ok", data_sram_addr_ok, 1);
        step(); data_sram_req = 0; data_sram_wr = 0;
        inst_sram_req = 1; inst_sram_addr = 32'h1C00_0040; #1;
        chk("t4_aw_w_same", {awvalid, wvalid}, 2'b11);
        chk("t4_inst_addr_ok", inst_sram_addr_ok, 1);
        step(); inst_sram_req = 0; awready = 0; wready = 0; #1;
        chk("t4_bready", bready, 1);
        chk("t4_arvalid", arvalid, 1);
        chk("t4_arid", arid, 0);
        step(); rvalid = 1; rdata = 32'hCAFE_F00D; #1;
        chk("t4_inst_data_ok", inst_sram_data_ok, 1);
        chk("t4_inst_rdata", inst_sram_rdata, 32'hCAFE_F00D);
        chk("t4_data_ok_0", data_sram_data_ok, 0);
        step(); rvalid = 0; bvalid = 1; #1;
        chk("t4_data_ok_b", data_sram_data_ok, 1);
        chk("t4_inst_data_ok_0", inst_sram_data_ok, 0);
        step(); bvalid = 0; #1;
        chk("t4_bready_idle", bready, 0);

        // 5: asynchronous reset while in R_R
        inst_sram_req = 1; inst_sram_addr = 32'h777; #1;
        chk("t5_addr_ok", inst_sram_addr_ok, 1);
        step(); inst_sram_req = 0; arready = 1;
        step(); #1;
        chk("t5_rready_pre", rready, 1);
        reset = 1; #1;
        chk("t5_rready_rst", rready, 0);
        chk("t5_arvalid_rst", arvalid, 0);
        chk("t5_araddr_rst", araddr, 0);
        chk("t5_data_ok_rst", inst_sram_data_ok, 0);
        step(); reset = 0;
        step();
        inst_sram_req = 1; inst_sram_addr = 32'h500; #1;
        chk("t5_new_addr_ok", inst_sram_addr_ok, 1);
        step(); inst_sram_req = 0; #1;
        chk("t5_new_araddr", araddr, 32'h500);
        step(); rvalid = 1; rdata = 32'h5555_0000; #1;
        chk("t5_new_data_ok", inst_sram_data_ok, 1);
        step(); rvalid = 0;

        // 6: arready held low for 10 cycles
        arready = 0;
        data_sram_req = 1; data_sram_wr = 0; data_sram_addr = 32'h600; #1;
        chk("t6_addr_ok", data_sram_addr_ok, 1);
        step(); data_sram_req = 0; inst_sram_req = 1; inst_sram_addr = 32'h800;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk($sformatf("t6_arvalid_%0d", i), arvalid, 1);
            chk($sformatf("t6_araddr_%0d", i), araddr, 32'h600);
            chk($sformatf("t6_inst_blk_%0d", i), inst_sram_addr_ok, 0);
            step();
        end
        arready = 1;
        step(); arready = 0; inst_sram_req = 0; rvalid = 1; rdata = 32'h6666_6666; #1;
        chk("t6_data_ok", data_sram_data_ok, 1);
        chk("t6_arvalid_done", arvalid, 0);
        step(); rvalid = 0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sram_axi_bridge.md
Name: sram_axi_bridge

Overview:
Downstream of the CPU top-level SRAM-like ports. Takes the inst and data SRAM-like request/addr_ok/data_ok channels and converts them into single-beat AXI3 master transactions. Sits between the core wrapper and the SoC AXI crossbar. At most one read and one write are outstanding at a time.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width (only 32 is supported)
ID_W, 4, AXI ID width

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
inst_sram_req/wr/size/wstrb/addr/wdata  in  1/1/2/4/ADDR_W/DATA_W  inst request; wr, wstrb and wdata are ignored
inst_sram_addr_ok  out  1  inst request accepted this cycle
inst_sram_data_ok  out  1  inst read data valid this cycle
inst_sram_rdata  out  DATA_W  inst read data
data_sram_req/wr/size/wstrb/addr/wdata  in  1/1/2/4/ADDR_W/DATA_W  data request
data_sram_addr_ok  out  1  data request accepted this cycle
data_sram_data_ok  out  1  data read data valid, or write complete
data_sram_rdata  out  DATA_W  data read data
arid/araddr/arsize/arvalid  out  ID_W/ADDR_W/3/1  AR channel
arready  in  1  AR channel ready
rid/rdata/rresp/rlast/rvalid  in  ID_W/DATA_W/2/1/1  R channel
rready  out  1  R channel ready
awid/awaddr/awsize/awvalid  out  ID_W/ADDR_W/3/1  AW channel
awready  in  1  AW channel ready
wid/wdata/wstrb/wlast/wvalid  out  ID_W/DATA_W/4/1/1  W channel
wready  in  1  W channel ready
bid/bresp/bvalid  in  ID_W/2/1  B channel
bready  out  1  B channel ready
ar/aw len,burst,lock,cache,prot  out  4,2,2,4,3 each  constants: len=0, burst=INCR(01), lock=0, cache=0, prot=0

Behaviour:
- Reset, asynchronous: both FSMs go to IDLE. All valid/ready/ok outputs are 0. All address/data/id registers are 0.
- Read FSM states: R_IDLE -> R_AR (on accept) -> R_R (on arvalid&&arready) -> R_IDLE (on rvalid&&rready).
- Write FSM states: W_IDLE -> W_REQ (on accept) -> W_B (once both AW and W have handshaken) -> W_IDLE (on bvalid&&bready).
- In W_REQ, awvalid and wvalid are independent. Each deasserts after its own handshake. The AW and W handshakes may complete in either order or in the same cycle.
- Accept rules (addr_ok is combinational, asserted in the same cycle as req):
  - data_busy = a data read or a data write is outstanding.
  - data write: accepted if data_sram_req && wr && W_IDLE && !data_busy.
  - data read: accepted if data_sram_req && !wr && R_IDLE && W_IDLE && !data_busy. A data read never overtakes a pending write.
  - inst read: accepted if inst_sram_req && R_IDLE && no data read is accepted in the same cycle. When inst and data reads collide, the data read wins.
  - An inst read may be outstanding while a data write is in flight.
- On accept, the bridge latches addr, size, wstrb, wdata and the source.
  - arid/awid: 0 for inst, 1 for data.
  - arsize/awsize = {1'b0, size}.
  - wlast = 1 with wvalid.
- arvalid is registered and goes high the cycle after accept. Minimum read latency: accept in cycle N, AR handshake in N+1, data_ok in N+2.
- rready = 1 only in R_R. The R beat is routed by the latched source, not by rid.
  - <src>_data_ok = rvalid in R_R, combinational.
  - <src>_rdata = rdata, combinational.
- bready = 1 only in W_B. data_sram_data_ok = bvalid in W_B.
- The data_busy rule guarantees read and write completions never coincide on data_sram_data_ok.
- rresp, bresp, rlast, rid and bid are ignored; no error reporting.
- Inputs are held by the master while waiting for addr_ok. The bridge does not depend on them after accept.
- A reset mid-transaction abandons the transaction; the slave is reset together with the bridge.

Decomposition:
- Package sram_axi_pkg holds:
  - read/write state enums
  - ID_INST=0, ID_DATA=1, BURST_INCR=2'b01
  - the AXI constant tie-off values
- No sub-module is required. The read and write FSMs are two always blocks in one module.

Test Plan:
- Inst read 0x1C000000, arready=1, R returns 0xDEADBEEF one cycle later -> inst_addr_ok in cycle 0, arvalid in cycle 1 (arid=0, arsize=2), inst_data_ok with rdata 0xDEADBEEF in cycle 2.
- Inst and data reads requested in the same cycle -> data_addr_ok=1, inst_addr_ok=0; inst accepted after the data R handshake, with arid=1 then arid=0.
- Data write addr 0x100, wstrb 0011, size 1, with wready arriving 3 cycles after awready -> awsize=1, wstrb=0011, wlast=1; data_data_ok only on bvalid; data read to 0x100 issued meanwhile gets no addr_ok until the write completes.
- Data write outstanding plus an inst read -> inst read is accepted and completes while the write waits for B.
- Assert reset while in R_R with arvalid previously handshaken -> all outputs 0 immediately; a fresh read after reset completes normally.
- arready held low for 10 cycles -> arvalid and araddr stay stable; no further addr_ok until the transaction completes.
